chunk_head_multi: RTL and testbench

CHUNK_HEAD_MULTI -- requirements
Module: chunk_head_multi

---
 rtl/chunk_head_multi_pkg.sv | 20 ++
 rtl/chunk_head_multi_next_enabled.sv | 26 ++
 rtl/chunk_head_multi_shuf_accum.sv | 27 ++
 rtl/chunk_head_multi.sv | 249 ++++++++++++++++++++++++
 tb/tb_chunk_head_multi.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chunk_head_multi_pkg.sv
// rtl/chunk_head_multi_pkg.sv - shared defaults and state type for chunk_head_multi
// Holds default geometry (config count, memory/loop dims, address, offset and
// stride widths) and the controller state enum used by the top level.
package chunk_head_multi_pkg;

    localparam int N_ICFG         = 4;
    localparam int DIM            = 4;
    localparam int VDIM           = 6;
    localparam int GLOBAL_ADDR_BW = 32;
    localparam int WORK_BW        = 16;
    localparam int STRIDE_BW      = 3;
    localparam int STRIDE_FRAC_BW = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/chunk_head_multi_next_enabled.sv
// rtl/chunk_head_multi_next_enabled.sv - lowest enabled config index at or above a start index
// Ports: mask (per-config enable), start (first index to consider),
//        found (some index qualifies), idx (lowest qualifying index, 0 if none).
module cfg_next_enabled #(
    parameter int N = 4,
    parameter int W = 3
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (W'(i) >= start)) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/chunk_head_multi_shuf_accum.sv
// rtl/chunk_head_multi_shuf_accum.sv - N-dimensional shuffle-accumulate of stride terms
// Ports: base (per-dim start address), terms (per-term addend), shufs (target dim
//        per term, values >= DIM contribute nothing), sums (per-dim result mod 2^GBW).
module nd_shuf_accum #(
    parameter int DIM    = 4,
    parameter int NT     = 12,
    parameter int GBW    = 32,
    parameter int DIM_BW = 3
) (
    input  logic [DIM-1:0][GBW-1:0]   base,
    input  logic [NT-1:0][GBW-1:0]    terms,
    input  logic [NT-1:0][DIM_BW-1:0] shufs,
    output logic [DIM-1:0][GBW-1:0]   sums
);

    always_comb begin
        sums = base;
        for (int d = 0; d < DIM; d++) begin
            for (int t = 0; t < NT; t++) begin
                if (shufs[t] == DIM_BW'(d)) begin
                    sums[d] = sums[d] + terms[t];
                end
            end
        end
    end

endmodule

// File: rtl/chunk_head_multi.sv
// rtl/chunk_head_multi.sv - walks the enabled access configs of a chunk and emits one global offset per config
// Optional feature macro: CHUNK_HEAD_MULTI_PIPE_EN (registers stride products, latency 2).
// Ports: i_clk/i_rst (async active-high); i_abofs_rdy/i_abofs_ack chunk handshake with
//        i_bofs/i_aofs offsets, i_beg/i_end id range, i_cfg_en mask; i_global_* per-config
//        tables; o_mofs_rdy/o_mofs_ack output handshake with o_mofs, o_id, o_last.
module chunk_head_multi #(
    parameter int N_ICFG = chunk_head_multi_pkg::N_ICFG,
    parameter int DIM    = chunk_head_multi_pkg::DIM,
    parameter int VDIM   = chunk_head_multi_pkg::VDIM,
    parameter int GBW    = chunk_head_multi_pkg::GLOBAL_ADDR_BW,
    parameter int WBW    = chunk_head_multi_pkg::WORK_BW,
    parameter int SF_BW  = chunk_head_multi_pkg::STRIDE_FRAC_BW,
    parameter int SS_BW  = chunk_head_multi_pkg::STRIDE_BW,
    localparam int ICFG_BW = $clog2(N_ICFG + 1),
    localparam int DIM_BW  = $clog2(DIM + 1)
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_abofs_rdy,
    output logic                                    i_abofs_ack,
    input  logic [VDIM-1:0][WBW-1:0]                i_bofs,
    input  logic [VDIM-1:0][WBW-1:0]                i_aofs,
    input  logic [ICFG_BW-1:0]                      i_beg,
    input  logic [ICFG_BW-1:0]                      i_end,
    input  logic [N_ICFG-1:0]                       i_cfg_en,
    input  logic [N_ICFG-1:0][DIM-1:0][GBW-1:0]     i_global_mofs,
    input  logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0] i_global_bshufs,
    input  logic [N_ICFG-1:0][VDIM-1:0][DIM_BW-1:0] i_global_ashufs,
    input  logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]  i_bstrides_frac,
    input  logic [N_ICFG-1:0][VDIM-1:0][SF_BW-1:0]  i_astrides_frac,
    input  logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]  i_bstrides_shamt,
    input  logic [N_ICFG-1:0][VDIM-1:0][SS_BW-1:0]  i_astrides_shamt,
    output logic                                    o_mofs_rdy,
    input  logic                                    o_mofs_ack,
    output logic [DIM-1:0][GBW-1:0]                 o_mofs,
    output logic [ICFG_BW-1:0]                      o_id,
    output logic                                    o_last
);

    import chunk_head_multi_pkg::*;

    localparam int IDX_BW = (N_ICFG > 1) ? $clog2(N_ICFG) : 1;
    localparam int NT     = 2 * VDIM;

    state_t state_q, state_d;

    logic [VDIM-1:0][WBW-1:0] bofs_q, aofs_q;
    logic [N_ICFG-1:0]        mask_q;
    logic [ICFG_BW-1:0]       nxt_q;

    logic                     idle, accept, issue;
    logic [N_ICFG-1:0]        in_mask, src_mask;
    logic [ICFG_BW-1:0]       src_start, after_start;
    logic [VDIM-1:0][WBW-1:0] src_bofs, src_aofs;

    logic               iss_found, more_found, iss_last;
    logic [ICFG_BW-1:0] iss_id, more_id;
    logic [IDX_BW-1:0]  iss_sel, acc_sel;

    logic [NT-1:0][GBW-1:0]    iss_terms, acc_terms;
    logic [NT-1:0][DIM_BW-1:0] acc_shufs;
    logic [DIM-1:0][GBW-1:0]   acc_mofs;

`ifdef CHUNK_HEAD_MULTI_PIPE_EN
    logic                   p_valid_q, p_last_q;
    logic [ICFG_BW-1:0]     p_id_q;
    logic [NT-1:0][GBW-1:0] p_terms_q;
    logic                   out_adv, p_adv;
`endif

    // Range-qualified enable mask of the chunk being offered.
    always_comb begin
        in_mask = '0;
        for (int i = 0; i < N_ICFG; i++) begin
            in_mask[i] = i_cfg_en[i] && (ICFG_BW'(i) >= i_beg) && (ICFG_BW'(i) < i_end);
        end
    end

    // While idle the issuer looks straight at the offered chunk so the first
    // id can be issued in the accept cycle; afterwards it walks the latched copy.
    assign idle      = (state_q == ST_IDLE);
    assign src_mask  = idle ? in_mask : mask_q;
    assign src_start = idle ? i_beg   : nxt_q;
    assign src_bofs  = idle ? i_bofs  : bofs_q;
    assign src_aofs  = idle ? i_aofs  : aofs_q;

    cfg_next_enabled #(.N(N_ICFG), .W(ICFG_BW)) u_first (
        .mask  (src_mask),
        .start (src_start),
        .found (iss_found),
        .idx   (iss_id)
    );

    // A second search past the issued id tells whether it is the chunk's last.
    assign after_start = iss_id + ICFG_BW'(1);

    cfg_next_enabled #(.N(N_ICFG), .W(ICFG_BW)) u_after (
        .mask  (src_mask),
        .start (after_start),
        .found (more_found),
        .idx   (more_id)
    );

    assign iss_last = ~more_found;
    assign iss_sel  = iss_id[IDX_BW-1:0];

    // Stride terms: b-terms in [0,VDIM), a-terms in [VDIM,2*VDIM).
    always_comb begin
        iss_terms = '0;
        for (int v = 0; v < VDIM; v++) begin
            iss_terms[v] = (GBW'(src_bofs[v]) * GBW'(i_bstrides_frac[iss_sel][v]))
                           << i_bstrides_shamt[iss_sel][v];
            iss_terms[VDIM + v] = (GBW'(src_aofs[v]) * GBW'(i_astrides_frac[iss_sel][v]))
                                  << i_astrides_shamt[iss_sel][v];
        end
    end

`ifdef CHUNK_HEAD_MULTI_PIPE_EN
    assign acc_sel   = p_id_q[IDX_BW-1:0];
    assign acc_terms = p_terms_q;
`else
    assign acc_sel   = iss_sel;
    assign acc_terms = iss_terms;
`endif

    always_comb begin
        acc_shufs = '0;
        for (int v = 0; v < VDIM; v++) begin
            acc_shufs[v]        = i_global_bshufs[acc_sel][v];
            acc_shufs[VDIM + v] = i_global_ashufs[acc_sel][v];
        end
    end

    nd_shuf_accum #(.DIM(DIM), .NT(NT), .GBW(GBW), .DIM_BW(DIM_BW)) u_accum (
        .base  (i_global_mofs[acc_sel]),
        .terms (acc_terms),
        .shufs (acc_shufs),
        .sums  (acc_mofs)
    );

    assign accept      = idle && i_abofs_rdy;
    assign i_abofs_ack = accept && !i_rst;

    // Next-state and issue control.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
`ifdef CHUNK_HEAD_MULTI_PIPE_EN
        out_adv = !o_mofs_rdy || o_mofs_ack;
        p_adv   = !p_valid_q || out_adv;
        case (state_q)
            ST_IDLE: begin
                if (accept && iss_found) begin
                    issue   = 1'b1;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                issue   = iss_found;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                issue = p_adv && iss_found;
                if (o_mofs_ack && o_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`else
        case (state_q)
            ST_IDLE: begin
                if (accept && iss_found) begin
                    issue   = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (o_mofs_ack) begin
                    if (o_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        issue = iss_found;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            bofs_q     <= '0;
            aofs_q     <= '0;
            mask_q     <= '0;
            nxt_q      <= '0;
            o_mofs_rdy <= 1'b0;
            o_mofs     <= '0;
            o_id       <= '0;
            o_last     <= 1'b0;
`ifdef CHUNK_HEAD_MULTI_PIPE_EN
            p_valid_q  <= 1'b0;
            p_last_q   <= 1'b0;
            p_id_q     <= '0;
            p_terms_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                bofs_q <= i_bofs;
                aofs_q <= i_aofs;
                mask_q <= in_mask;
            end
            if (issue) begin
                nxt_q <= after_start;
            end
`ifdef CHUNK_HEAD_MULTI_PIPE_EN
            if (p_adv) begin
                p_valid_q <= issue;
            end
            if (issue) begin
                p_terms_q <= iss_terms;
                p_id_q    <= iss_id;
                p_last_q  <= iss_last;
            end
            if (out_adv) begin
                o_mofs_rdy <= p_valid_q;
                if (p_valid_q) begin
                    o_mofs <= acc_mofs;
                    o_id   <= p_id_q;
                    o_last <= p_last_q;
                end
            end
`else
            if (issue) begin
                o_mofs_rdy <= 1'b1;
                o_mofs     <= acc_mofs;
                o_id       <= iss_id;
                o_last     <= iss_last;
            end else if (o_mofs_ack) begin
                o_mofs_rdy <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_chunk_head_multi.sv
// tb/tb_chunk_head_multi.sv - self-checking bench for chunk_head_multi
module tb_chunk_head_multi;

    localparam int N    = 4;
    localparam int DIM  = 4;
    localparam int VDIM = 6;
    localparam int GBW  = 32;
    localparam int WBW  = 16;
    localparam int SF   = 2;
    localparam int SS   = 3;
    localparam int IB   = 3;
    localparam int DB   = 3;
`ifdef CHUNK_HEAD_MULTI_PIPE_EN
    localparam int LAT  = 2;
`else
    localparam int LAT  = 1;
`endif

    logic                             clk = 1'b0;
    logic                             rst;
    logic                             abofs_rdy, abofs_ack;
    logic [VDIM-1:0][WBW-1:0]         bofs, aofs;
    logic [IB-1:0]                    beg, end_id;
    logic [N-1:0]                     cfg_en;
    logic [N-1:0][DIM-1:0][GBW-1:0]   gmofs;
    logic [N-1:0][VDIM-1:0][DB-1:0]   bshuf, ashuf;
    logic [N-1:0][VDIM-1:0][SF-1:0]   bfrac, afrac;
    logic [N-1:0][VDIM-1:0][SS-1:0]   bsh, ash;
    logic                             mofs_rdy, mofs_ack;
    logic [DIM-1:0][GBW-1:0]          mofs;
    logic [IB-1:0]                    oid;
    logic                             olast;

    always #5 clk = ~clk;

    chunk_head_multi dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_abofs_rdy      (abofs_rdy),
        .i_abofs_ack      (abofs_ack),
        .i_bofs           (bofs),
        .i_aofs           (aofs),
        .i_beg            (beg),
        .i_end            (end_id),
        .i_cfg_en         (cfg_en),
        .i_global_mofs    (gmofs),
        .i_global_bshufs  (bshuf),
        .i_global_ashufs  (ashuf),
        .i_bstrides_frac  (bfrac),
        .i_astrides_frac  (afrac),
        .i_bstrides_shamt (bsh),
        .i_astrides_shamt (ash),
        .o_mofs_rdy       (mofs_rdy),
        .o_mofs_ack       (mofs_ack),
        .o_mofs           (mofs),
        .o_id             (oid),
        .o_last           (olast)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int                      id;
        logic [DIM-1:0][GBW-1:0] m;
        bit                      last;
    } exp_t;

    exp_t            exp_q[$];
    int              log_id[$];
    bit              log_last[$];
    int              log_cyc[$];
    logic [GBW-1:0]  log_m1[$];
    int              cyc       = 0;
    int              ready_due = 0;
    int              acc_cyc   = 0;
    bit              chk_en    = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [GBW-1:0] term(input logic [WBW-1:0] o, input logic [SF-1:0] f,
                                            input logic [SS-1:0] s);
        logic [63:0] p;
        p = (64'(o) * 64'(f)) << s;
        return p[GBW-1:0];
    endfunction

    // Expected outputs of the chunk currently on the inputs, in emission order.
    task automatic model_chunk();
        exp_t        e;
        int          last_id = -1;
        logic [63:0] sum;
        for (int id = 0; id < N; id++)
            if (id >= int'(beg) && id < int'(end_id) && cfg_en[id]) last_id = id;
        for (int id = 0; id < N; id++) begin
            if (id >= int'(beg) && id < int'(end_id) && cfg_en[id]) begin
                e.id   = id;
                e.last = (id == last_id);
                for (int d = 0; d < DIM; d++) begin
                    sum = 64'(gmofs[id][d]);
                    for (int v = 0; v < VDIM; v++) begin
                        if (int'(bshuf[id][v]) == d) sum += 64'(term(bofs[v], bfrac[id][v], bsh[id][v]));
                        if (int'(ashuf[id][v]) == d) sum += 64'(term(aofs[v], afrac[id][v], ash[id][v]));
                    end
                    e.m[d] = sum[GBW-1:0];
                end
                exp_q.push_back(e);
            end
        end
    endtask

    // Compare process: every falling edge, outputs against the model queue.
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            if (rst) begin
                check("reset_outputs", {mofs_rdy, olast, abofs_ack, oid, mofs}, '0);
                exp_q.delete();
            end else begin
                check("abofs_ack", abofs_ack, abofs_rdy && (exp_q.size() == 0));
                if (exp_q.size() > 0 && cyc >= ready_due) begin
                    check("mofs_rdy_due", mofs_rdy, 1'b1);
                    if (mofs_rdy) begin
                        check("o_id", oid, exp_q[0].id);
                        check("o_last", olast, exp_q[0].last);
                        check("o_mofs", mofs, exp_q[0].m);
                        if (mofs_ack) begin
                            log_id.push_back(int'(oid));
                            log_last.push_back(olast);
                            log_cyc.push_back(cyc);
                            log_m1.push_back(mofs[1]);
                            void'(exp_q.pop_front());
                            ready_due = cyc + 1;
                        end
                    end
                end else begin
                    check("mofs_rdy_quiet", mofs_rdy, 1'b0);
                end
                if (abofs_rdy && abofs_ack) begin
                    acc_cyc = cyc;
                    model_chunk();
                    ready_due = cyc + LAT;
                end
            end
        end
    end

    task automatic clear_logs();
        log_id.delete();
        log_last.delete();
        log_cyc.delete();
        log_m1.delete();
    endtask

    task automatic clear_cfg();
        bofs = '0; aofs = '0; gmofs = '0;
        bshuf = '0; ashuf = '0; bfrac = '0; afrac = '0; bsh = '0; ash = '0;
    endtask

    task automatic rand_cfg();
        for (int v = 0; v < VDIM; v++) begin
            bofs[v] = 16'($urandom);
            aofs[v] = 16'($urandom);
        end
        for (int id = 0; id < N; id++) begin
            for (int d = 0; d < DIM; d++) gmofs[id][d] = $urandom;
            for (int v = 0; v < VDIM; v++) begin
                bshuf[id][v] = 3'($urandom_range(0, 7));
                ashuf[id][v] = 3'($urandom_range(0, 7));
                bfrac[id][v] = 2'($urandom_range(0, 3));
                afrac[id][v] = 2'($urandom_range(0, 3));
                bsh[id][v]   = 3'($urandom_range(0, 7));
                ash[id][v]   = 3'($urandom_range(0, 7));
            end
        end
    endtask

    task automatic send(input int b, input int e, input logic [N-1:0] m, output int acc);
        bit got = 1'b0;
        beg = IB'(b); end_id = IB'(e); cfg_en = m; abofs_rdy = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = abofs_ack;
            @(posedge clk); #1;
        end
        abofs_rdy = 1'b0;
        check("send_accepted", got, 1'b1);
        acc = acc_cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_seq(input string tag, input int ids[$], input int base, input bit timed);
        check({tag, "_count"}, log_id.size(), ids.size());
        for (int k = 0; k < ids.size() && k < log_id.size(); k++) begin
            check({tag, "_id"}, log_id[k], ids[k]);
            check({tag, "_last"}, log_last[k], k == ids.size() - 1);
            if (timed) check({tag, "_cycle"}, log_cyc[k], base + LAT + k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a1, a2, stall;
        rst = 1'b1; abofs_rdy = 1'b1; mofs_ack = 1'b1;
        beg = '0; end_id = '0; cfg_en = '0;
        clear_cfg();
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", mofs_rdy, 1'b0);
        check("rst_mofs", mofs, '0);
        check("rst_id", oid, '0);
        check("rst_last", olast, 1'b0);
        check("rst_ack", abofs_ack, 1'b0);
        abofs_rdy = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        // All four enabled, ack held high.
        rand_cfg(); clear_logs();
        send(0, 4, 4'b1111, a1); wait_idle();
        check_seq("all4", '{0, 1, 2, 3}, a1, 1'b1);

        // Alternate mask.
        rand_cfg(); clear_logs();
        send(0, 4, 4'b1010, a1); wait_idle();
        check_seq("m1010", '{1, 3}, a1, 1'b1);

        // Empty chunks: accepted, nothing emitted, next chunk accepted next cycle.
        clear_logs();
        send(2, 2, 4'b1111, a1);
        send(0, 1, 4'b0001, a2);
        check("empty_next_accept", a2, a1 + 1);
        wait_idle();
        check_seq("after_empty", '{0}, a2, 1'b1);
        clear_logs();
        send(0, 2, 4'b1100, a1);
        send(3, 1, 4'b1111, a1);
        repeat (4) @(posedge clk);
        #1;
        check("no_enabled_count", log_id.size(), 0);

        // Literal address arithmetic with dropped terms, then wraparound.
        clear_cfg(); clear_logs();
        bofs[0] = 16'd3; bfrac[0][0] = 2'd3; bsh[0][0] = 3'd2; bshuf[0][0] = 3'd1;
        gmofs[0][1] = 32'd100;
        bofs[1] = 16'd7; bfrac[0][1] = 2'd1; bshuf[0][1] = 3'd5;
        aofs[2] = 16'd9; afrac[0][2] = 2'd2; ashuf[0][2] = 3'd4;
        send(0, 1, 4'b0001, a1); wait_idle();
        check("lit_count", log_m1.size(), 1);
        if (log_m1.size() > 0) check("lit_136", log_m1[0], 32'd136);
        clear_logs();
        gmofs[0][1] = 32'hFFFF_FFFF;
        bofs[0] = 16'd1; bfrac[0][0] = 2'd1; bsh[0][0] = 3'd0;
        send(0, 1, 4'b0001, a1); wait_idle();
        check("wrap_count", log_m1.size(), 1);
        if (log_m1.size() > 0) check("wrap_zero", log_m1[0], 32'd0);

        // Five-cycle stall on id 1.
        rand_cfg(); clear_logs();
        mofs_ack = 1'b0; stall = 0;
        send(0, 4, 4'b1111, a1);
        for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
            if (mofs_rdy && oid == 3'd1 && stall < 5) begin
                mofs_ack = 1'b0;
                stall++;
            end else begin
                mofs_ack = 1'b1;
            end
            @(posedge clk); #1;
        end
        mofs_ack = 1'b1;
        wait_idle();
        check_seq("stall", '{0, 1, 2, 3}, a1, 1'b0);
        if (log_cyc.size() == 4) begin
            check("stall_gap", log_cyc[1] - log_cyc[0], 6);
            check("stall_resume", log_cyc[2] - log_cyc[1], 1);
        end

        // Varied chunks with a toggling ack.
        for (int t = 0; t < 3; t++) begin
            rand_cfg();
            send(t, 4, 4'b1011 ^ 4'(t), a1);
            for (int n = 0; n < 80 && exp_q.size() > 0; n++) begin
                mofs_ack = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            mofs_ack = 1'b1;
            wait_idle();
        end

        // Reset in the middle of a chunk.
        rand_cfg(); mofs_ack = 1'b0;
        send(0, 4, 4'b1111, a1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; mofs_ack = 1'b1; clear_logs();
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_silent", log_id.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
